// File: rtl/observer_seq.sv
// Synchronous channel observer. It registers the selected channel, the OR/XOR reduction flags
// and the rise/fall edges, and keeps a saturating edge count and a sliding-window pattern match.
module observer_seq #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8,
  parameter int HIST_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [NUM_CH-1:0] In,
  input  logic [SEL_W-1:0]  Sel,
  input  logic [HIST_W-1:0] Pattern,
  input  logic              ClrCnt,
  output logic              MuxOut,
  output logic              AnyActive,
  output logic              Parity,
  output logic              Rise,
  output logic              Fall,
  output logic [CNT_W-1:0]  EdgeCnt,
  output logic              CntSat,
  output logic              Match
);

  localparam int FILL_W = $clog2(HIST_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(HIST_W);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

  logic              cur;
  logic              sel_chg;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              prev_q, prev_d;
  logic              mux_q, mux_d;
  logic              any_q, any_d;
  logic              par_q, par_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              match_q, match_d;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;

  always_comb begin
    cur = In[0];
    if (int'(Sel) < NUM_CH) cur = In[Sel];
    sel_chg = (Sel != sel_q);

    sel_d   = Sel;
    prev_d  = cur;
    mux_d   = 1'b0;
    any_d   = 1'b0;
    par_d   = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    match_d = 1'b0;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;

    if (Enable) begin
      mux_d = cur;
      any_d = |In;
      par_d = ^In;
      if (sel_chg) begin
        // A new channel restarts the history with this sample as its first entry.
        hist_d = {{(HIST_W-1){1'b0}}, cur};
        fill_d = FILL_ONE;
      end else begin
        rise_d = !prev_q && cur;
        fall_d = prev_q && !cur;
        hist_d = {hist_q[HIST_W-2:0], cur};
        if (fill_q != FILL_MAX) fill_d = fill_q + FILL_ONE;
      end
      match_d = !sel_chg && (fill_d == FILL_MAX) && (hist_d == Pattern);
    end

    if (ClrCnt) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (rise_d || fall_d) begin
      if (cnt_q == {CNT_W{1'b1}}) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == {CNT_W{1'b1}}) sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sel_q   <= '0;
      prev_q  <= 1'b0;
      mux_q   <= 1'b0;
      any_q   <= 1'b0;
      par_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      match_q <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      prev_q  <= prev_d;
      mux_q   <= mux_d;
      any_q   <= any_d;
      par_q   <= par_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      match_q <= match_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign MuxOut    = mux_q;
  assign AnyActive = any_q;
  assign Parity    = par_q;
  assign Rise      = rise_q;
  assign Fall      = fall_q;
  assign EdgeCnt   = cnt_q;
  assign CntSat    = sat_q;
  assign Match     = match_q;

endmodule
